// File: rtl/spi_txn_arbiter_if.sv
// Bundle between the requesters, the arbiter and the SPI byte engine.
// The arbiter uses the slave modport; the requester/engine side uses master.
interface spi_txn_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   cs_n;
  logic              eng_start;
  logic [7:0]        eng_tx;
  logic              eng_done;
  logic [7:0]        eng_rx;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req, req_data, eng_done, eng_rx,
    output gnt, cs_n, eng_start, eng_tx, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req, req_data, eng_done, eng_rx,
    input  gnt, cs_n, eng_start, eng_tx, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI mode-0 byte engine among NREQ
// requesters. Each grant runs: chip-select setup, engine start, wait for done
// (or timeout), chip-select hold, then a chip-select-high gap.
module spi_txn_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned GAP      = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic              clk,
  input logic              rst_n,
  spi_txn_arbiter_if.slave bus
);
  localparam int unsigned IdW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MaxSh = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned MaxGt = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int unsigned MaxLd = (MaxSh > MaxGt) ? MaxSh : MaxGt;
  // One shared down-counter, wide enough for the largest interval.
  localparam int unsigned CntW  = $clog2(MaxLd) + 1;

  // Reload values: a state lasting N cycles loads N-1 and leaves at zero.
  localparam logic [CntW-1:0] SetupLd   = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLd    = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] GapLd     = CntW'(GAP - 1);
  localparam logic [CntW-1:0] TimeoutLd = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StStart, StWait, StHold, StGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdW-1:0]  last_id_q;
  logic [IdW-1:0]  cur_id_q;

  logic            win_found;
  logic [IdW-1:0]  win_id;
  logic [IdW-1:0]  cand;
  logic [NREQ-1:0] win_oh;

  // Round-robin pick: search from last_id+1 upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IdW'((32'(last_id_q) + off) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // One-hot form of the winner for gnt and cs_n.
  always_comb begin
    win_oh         = '0;
    win_oh[win_id] = 1'b1;
  end

  // Sequencer FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_id_q     <= IdW'(NREQ - 1);
      cur_id_q      <= '0;
      bus.gnt       <= '0;
      bus.cs_n      <= '1;
      bus.eng_start <= 1'b0;
      bus.eng_tx    <= 8'h00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 3'd0;
      bus.rsp_data  <= 8'h00;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.gnt       <= '0;
      bus.eng_start <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            cur_id_q   <= win_id;
            bus.gnt    <= win_oh;
            bus.cs_n   <= ~win_oh;
            bus.eng_tx <= bus.req_data[{win_id, 3'b000} +: 8];
            bus.rsp_id <= 3'(win_id);
            bus.busy   <= 1'b1;
            cnt_q      <= SetupLd;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            bus.eng_start <= 1'b1;
            state_q       <= StStart;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStart: begin
          cnt_q   <= TimeoutLd;
          state_q <= StWait;
        end
        StWait: begin
          // Done is checked first so it wins over a coincident timeout.
          if (bus.eng_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.eng_rx;
            bus.rsp_err   <= 1'b0;
            cnt_q         <= HoldLd;
            state_q       <= StHold;
          end else if (cnt_q == '0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= 8'h00;
            bus.rsp_err   <= 1'b1;
            cnt_q         <= HoldLd;
            state_q       <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            bus.cs_n <= '1;
            cnt_q    <= GapLd;
            state_q  <= StGap;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            last_id_q <= cur_id_q;
            bus.busy  <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: a behavioural byte engine plus a response
// scoreboard, advanced one clock at a time from the main thread.
module tb_spi_txn_arbiter;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned GAP      = 4;
  localparam int unsigned TIMEOUT  = 1024;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic clk;
  logic rst_n;

  spi_txn_arbiter_if #(.NREQ(NREQ)) bus ();

  spi_txn_arbiter #(
    .NREQ    (NREQ),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         errors;
  int         checks;
  rsp_t       sb[$];
  int         gnt_log[$];
  int         eng_cnt;
  int         eng_delay;
  bit         eng_mute;
  bit         hold_req;
  logic [7:0] eng_xor;
  logic [7:0] eng_tx_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic rsp_t mk(input int id, input logic [7:0] d, input logic e);
    return {3'(id), d, e};
  endfunction

  // Advance to the next falling edge, score responses/grants, run the engine model.
  task automatic step();
    rsp_t exp;
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%02h err=%0b, required no response",
                 bus.rsp_id, bus.rsp_data, bus.rsp_err);
      end else begin
        exp = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== exp) begin
          errors++;
          $display("FAIL rsp: got id=%0d data=%02h err=%0b, required id=%0d data=%02h err=%0b",
                   bus.rsp_id, bus.rsp_data, bus.rsp_err, exp.id, exp.data, exp.err);
        end
      end
    end
    if (bus.gnt !== '0) begin
      checks++;
      if (!$onehot(bus.gnt) || bus.cs_n !== ~bus.gnt) begin
        errors++;
        $display("FAIL gnt_cs: got gnt=%b cs_n=%b, required one-hot gnt with cs_n=~gnt",
                 bus.gnt, bus.cs_n);
      end
      for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gnt_log.push_back(i);
    end
    checks++;
    if ($countones(~bus.cs_n) > 1) begin
      errors++;
      $display("FAIL cs_excl: got cs_n=%b, required at most one low", bus.cs_n);
    end
    bus.eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.eng_done = 1'b1;
        bus.eng_rx   = eng_tx_seen ^ eng_xor;
      end
    end
    if (bus.eng_start === 1'b1 && !eng_mute) begin
      eng_cnt     = eng_delay;
      eng_tx_seen = bus.eng_tx;
    end
    if (!hold_req) bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    eng_cnt      = 0;
    bus.req      = '0;
    bus.eng_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_idle(input int max_cyc);
    int n;
    n = 0;
    while ((bus.req !== '0 || bus.busy !== 1'b0 || sb.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL idle_wait: got no idle after %0d cycles, required idle with empty scoreboard",
               n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks += 9;
    if (bus.gnt !== '0) begin
      errors++; $display("FAIL rst_gnt: got %b, required 0000", bus.gnt);
    end
    if (bus.cs_n !== '1) begin
      errors++; $display("FAIL rst_cs_n: got %b, required 1111", bus.cs_n);
    end
    if (bus.eng_start !== 1'b0) begin
      errors++; $display("FAIL rst_eng_start: got %b, required 0", bus.eng_start);
    end
    if (bus.eng_tx !== 8'h00) begin
      errors++; $display("FAIL rst_eng_tx: got %02h, required 00", bus.eng_tx);
    end
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid);
    end
    if (bus.rsp_id !== 3'd0) begin
      errors++; $display("FAIL rst_rsp_id: got %0d, required 0", bus.rsp_id);
    end
    if (bus.rsp_data !== 8'h00) begin
      errors++; $display("FAIL rst_rsp_data: got %02h, required 00", bus.rsp_data);
    end
    if (bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL rst_rsp_err: got %b, required 0", bus.rsp_err);
    end
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b, required 0", bus.busy);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.cs_n !== '1) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b cs_n=%b, required busy=0 cs_n=1111",
               bus.busy, bus.cs_n);
    end
  endtask

  task automatic test_single();
    int c, low, start_at, rsp_at, tx_bad;
    logic [7:0] tx_at_start;
    eng_delay = 19;
    eng_xor   = 8'hA5 ^ 8'h3C;
    bus.req_data[7:0] = 8'hA5;
    sb.push_back(mk(0, 8'h3C, 1'b0));
    bus.req = 4'b0001;
    step();
    checks += 2;
    if (bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL single_gnt: got %b, required 0001", bus.gnt);
    end
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_busy: got %b, required 1", bus.busy);
    end
    c = 1; low = 0; start_at = -1; rsp_at = -1; tx_bad = 0; tx_at_start = 8'h00;
    while (bus.cs_n[0] === 1'b0 && c < 200) begin
      low++;
      if (bus.eng_start === 1'b1) begin
        start_at    = c;
        tx_at_start = bus.eng_tx;
      end
      if (start_at > 0 && rsp_at < 0 && bus.eng_tx !== 8'hA5) tx_bad++;
      if (bus.rsp_valid === 1'b1) rsp_at = c;
      step();
      c++;
    end
    checks += 5;
    if (start_at != 1 + int'(CS_SETUP)) begin
      errors++; $display("FAIL single_start_cycle: got %0d, required %0d", start_at, 1 + CS_SETUP);
    end
    if (tx_at_start !== 8'hA5) begin
      errors++; $display("FAIL single_eng_tx: got %02h, required a5", tx_at_start);
    end
    if (tx_bad != 0) begin
      errors++; $display("FAIL single_tx_stable: got %0d unstable cycles, required 0", tx_bad);
    end
    if (rsp_at != 1 + int'(CS_SETUP) + 19 + 1) begin
      errors++; $display("FAIL single_rsp_cycle: got %0d, required %0d", rsp_at, CS_SETUP + 21);
    end
    if (low != int'(CS_SETUP) + 20 + int'(CS_HOLD)) begin
      errors++;
      $display("FAIL single_cs_low: got %0d cycles, required %0d", low, CS_SETUP + 20 + CS_HOLD);
    end
    run_idle(100);
  endtask

  task automatic test_contention();
    int c, high_run, windows;
    bit prev_low, any_low;
    logic [7:0] d [4];
    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_reset();
    gnt_log.delete();
    eng_delay = 3;
    eng_xor   = 8'h0F;
    for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = d[i];
    for (int k = 0; k < 5; k++) sb.push_back(mk(k % NREQ, d[k % NREQ] ^ 8'h0F, 1'b0));
    hold_req = 1'b1;
    bus.req  = '1;
    c = 0; high_run = 0; windows = 0; prev_low = 1'b0;
    while (c < 1000 && !(gnt_log.size() >= 5 && bus.busy === 1'b0 && sb.size() == 0)) begin
      step();
      c++;
      if (gnt_log.size() >= 5) bus.req = '0;
      any_low = (bus.cs_n !== '1);
      if (any_low && !prev_low) begin
        if (windows > 0) begin
          checks++;
          if (high_run != int'(GAP) + 1) begin
            errors++;
            $display("FAIL contention_gap: got %0d high cycles, required %0d", high_run, GAP + 1);
          end
        end
        windows++;
      end
      if (any_low) high_run = 0;
      else high_run++;
      prev_low = any_low;
    end
    hold_req = 1'b0;
    checks += 3;
    if (c >= 1000) begin
      errors++; $display("FAIL contention_wait: got timeout after %0d cycles, required idle", c);
    end
    if (gnt_log.size() != 5) begin
      errors++; $display("FAIL contention_ngnt: got %0d grants, required 5", gnt_log.size());
    end
    if (windows != 5) begin
      errors++; $display("FAIL contention_windows: got %0d cs windows, required 5", windows);
    end
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) begin
      checks++;
      if (gnt_log[k] != k % NREQ) begin
        errors++;
        $display("FAIL contention_order[%0d]: got id %0d, required %0d", k, gnt_log[k], k % NREQ);
      end
    end
  endtask

  task automatic test_fairness();
    gnt_log.delete();
    eng_delay = 2;
    eng_xor   = 8'hF0;
    bus.req_data[31:24] = 8'h9C;
    sb.push_back(mk(3, 8'h9C ^ 8'hF0, 1'b0));
    bus.req = 4'b1000;
    run_idle(200);
    bus.req_data[7:0] = 8'h01;
    sb.push_back(mk(0, 8'h01 ^ 8'hF0, 1'b0));
    sb.push_back(mk(3, 8'h9C ^ 8'hF0, 1'b0));
    bus.req = 4'b1001;
    run_idle(400);
    checks++;
    if (gnt_log.size() != 3) begin
      errors++; $display("FAIL fair_ngnt: got %0d grants, required 3", gnt_log.size());
    end else begin
      checks++;
      if (gnt_log[0] != 3 || gnt_log[1] != 0 || gnt_log[2] != 3) begin
        errors++;
        $display("FAIL fair_order: got %0d,%0d,%0d, required 3,0,3",
                 gnt_log[0], gnt_log[1], gnt_log[2]);
      end
    end
  endtask

  task automatic test_timeout();
    int c, start_at, rsp_at, rise_at;
    bit seen_low;
    eng_mute   = 1'b1;
    bus.eng_rx = 8'hEE;
    bus.req_data[23:16] = 8'h5E;
    sb.push_back(mk(2, 8'h00, 1'b1));
    bus.req = 4'b0100;
    c = 0; start_at = -1; rsp_at = -1; rise_at = -1; seen_low = 1'b0;
    while (rise_at < 0 && c < int'(TIMEOUT) + 200) begin
      step();
      c++;
      if (bus.eng_start === 1'b1) start_at = c;
      if (bus.rsp_valid === 1'b1) rsp_at = c;
      if (bus.cs_n[2] === 1'b0) seen_low = 1'b1;
      else if (seen_low) rise_at = c;
    end
    checks += 3;
    if (start_at < 0 || rsp_at < 0 || rise_at < 0) begin
      errors++;
      $display("FAIL timeout_events: got start=%0d rsp=%0d rise=%0d, required all seen",
               start_at, rsp_at, rise_at);
    end
    if (rsp_at - start_at != int'(TIMEOUT) + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d, required %0d", rsp_at - start_at, TIMEOUT + 1);
    end
    if (rise_at - rsp_at != int'(CS_HOLD)) begin
      errors++; $display("FAIL timeout_hold: got %0d, required %0d", rise_at - rsp_at, CS_HOLD);
    end
    run_idle(100);
    eng_mute = 1'b0;
  endtask

  task automatic test_coincident();
    int c, start_at, rsp_at;
    eng_delay = int'(TIMEOUT);
    eng_xor   = 8'h5A;
    bus.req_data[15:8] = 8'hC3;
    sb.push_back(mk(1, 8'hC3 ^ 8'h5A, 1'b0));
    bus.req = 4'b0010;
    c = 0; start_at = -1; rsp_at = -1;
    while (rsp_at < 0 && c < int'(TIMEOUT) + 200) begin
      step();
      c++;
      if (bus.eng_start === 1'b1) start_at = c;
      if (bus.rsp_valid === 1'b1) rsp_at = c;
    end
    checks++;
    if (rsp_at < 0 || rsp_at - start_at != int'(TIMEOUT) + 1) begin
      errors++;
      $display("FAIL coincident_latency: got %0d, required %0d", rsp_at - start_at, TIMEOUT + 1);
    end
    run_idle(100);
    eng_delay = 3;
  endtask

  task automatic test_spurious();
    int rsp_cnt, busy_cnt;
    rsp_cnt = 0; busy_cnt = 0;
    bus.eng_rx   = 8'h77;
    bus.eng_done = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid === 1'b1) rsp_cnt++;
      if (bus.busy !== 1'b0) busy_cnt++;
      step();
    end
    checks += 2;
    if (rsp_cnt != 0) begin
      errors++; $display("FAIL spurious_rsp: got %0d responses, required 0", rsp_cnt);
    end
    if (busy_cnt != 0) begin
      errors++; $display("FAIL spurious_busy: got %0d busy cycles, required 0", busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    eng_mute = 1'b1;
    bus.req  = 4'b0100;
    c = 0;
    while (bus.eng_start !== 1'b1 && c < 50) begin
      step();
      c++;
    end
    repeat (5) step();
    rst_n   = 1'b0;
    eng_cnt = 0;
    #1;
    checks += 4;
    if (bus.cs_n !== '1) begin
      errors++; $display("FAIL midrst_cs_n: got %b, required 1111", bus.cs_n);
    end
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: got %b, required 0", bus.busy);
    end
    if (bus.rsp_valid !== 1'b0 || bus.gnt !== '0) begin
      errors++;
      $display("FAIL midrst_pulses: got rsp_valid=%b gnt=%b, required 0 and 0000",
               bus.rsp_valid, bus.gnt);
    end
    if (bus.eng_tx !== 8'h00) begin
      errors++; $display("FAIL midrst_eng_tx: got %02h, required 00", bus.eng_tx);
    end
    repeat (2) step();
    rst_n    = 1'b1;
    eng_mute = 1'b0;
    step();
    gnt_log.delete();
    eng_xor = 8'h0F;
    bus.req_data[15:8] = 8'h42;
    sb.push_back(mk(1, 8'h42 ^ 8'h0F, 1'b0));
    bus.req = 4'b0010;
    run_idle(200);
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] != 1) begin
      errors++;
      $display("FAIL midrst_regrant: got %0d grants (first id %0d), required 1 grant to id 1",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.eng_done = 1'b0;
    bus.eng_rx   = 8'h00;
    eng_cnt      = 0;
    eng_delay    = 3;
    eng_mute     = 1'b0;
    hold_req     = 1'b0;
    eng_xor      = 8'h00;
    eng_tx_seen  = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_coincident();
    test_spurious();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
